// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin over WIDTH cycles, LSB first, valid/ready on both sides
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, bin sampled on accept)
//   out_valid/out_ready  result handshake (diff, bout, ovf held until accepted)
//   busy                 high while an operation is running or its result is pending
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
   logic             x, y, d, br_next, last;

   always_comb begin
      x       = a_q[0];
      y       = b_q[0];
      d       = x ^ y ^ br_q;
      br_next = (~x & y) | (~(x ^ y) & br_q);
      last    = cnt_q == CW'(WIDTH - 1);
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if (state_q == S_IDLE) begin
         if (in_valid) begin
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            cnt_d   = '0;
            state_d = S_RUN;
         end
      end else if (state_q == S_RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         // new difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
         r_d   = (r_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
         br_d  = br_next;
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            state_d = S_DONE;
            bout_d  = br_next;
            // signed overflow: borrow into the sign bit differs from borrow out of it
            ovf_d   = br_next ^ br_q;
         end
      end else if (out_ready) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign busy      = state_q != S_IDLE;
   assign diff      = r_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, bout, ovf, busy;
   logic [W-1:0] diff;

   int   checks = 0;
   int   failures = 0;
   int   accepts = 0;
   bit   m_busy = 1'b0;
   int   m_left = 0;
   logic [W+1:0] m_exp = '0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // {ovf, bout, diff} from plain integer arithmetic
   function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
      int u, s;
      logic [W-1:0] dv;
      u  = int'(x) - int'(y) - int'(bi);
      s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
      dv = W'(u);
      return {(s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1), u < 0, dv};
   endfunction

   // timeline model: accept when idle, result visible W edges later, released on out_ready
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", {in_ready, out_valid, busy, bout, ovf, diff}, {1'b1, 4'b0, 8'h00});
         m_busy = 1'b0;
      end else begin
         chk("in_ready", in_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("out_valid", out_valid, m_busy && m_left == 0);
         if (m_busy && m_left == 0) chk("result", {ovf, bout, diff}, m_exp);
         if (!m_busy) begin
            if (in_valid) begin
               m_busy = 1'b1;
               m_left = W;
               m_exp  = ref_sub(a, b, bin);
               accepts++;
            end
         end else if (m_left > 0) begin
            m_left--;
         end else if (out_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        input logic [W+1:0] exp, input int hold, input bit junk);
      int n;
      chk("ready_before_op", in_ready, 1'b1);
      in_valid = 1'b1;
      a = xa;
      b = xb;
      bin = xbin;
      @(posedge clk); #1;
      chk("busy_after_accept", {busy, in_ready}, 2'b10);
      if (junk) begin
         a = 8'($urandom);
         b = 8'($urandom);
         bin = 1'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, W);
      chk("result_literal", {ovf, bout, diff}, exp);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      chk("held_result", {out_valid, in_ready, ovf, bout, diff}, {2'b10, exp});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("ready_after_handshake", {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      chk("model_basic", ref_sub(8'h05, 8'h03, 1'b0), {2'b00, 8'h02});
      chk("model_neg", ref_sub(8'h03, 8'h05, 1'b0), {2'b01, 8'hFE});
      chk("model_ovf", ref_sub(8'h7F, 8'hFF, 1'b0), {2'b11, 8'h80});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(8'h05, 8'h03, 1'b0, {2'b00, 8'h02}, 0, 1'b0);
      do_op(8'h03, 8'h05, 1'b0, {2'b01, 8'hFE}, 0, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, {2'b01, 8'hFF}, 0, 1'b0);
      do_op(8'h80, 8'h00, 1'b1, {2'b10, 8'h7F}, 0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, {2'b10, 8'h7F}, 0, 1'b0);
      do_op(8'h7F, 8'hFF, 1'b0, {2'b11, 8'h80}, 0, 1'b0);
      do_op(8'hA5, 8'h3C, 1'b1, {2'b10, 8'h68}, 5, 1'b1);
      in_valid = 1'b1;
      a = 8'h55;
      b = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("reset_mid_run", {in_ready, out_valid, busy, bout, ovf, diff}, {1'b1, 4'b0, 8'h00});
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("no_valid_after_reset", out_valid, 1'b0);
      end
      do_op(8'h10, 8'h01, 1'b0, {2'b00, 8'h0F}, 0, 1'b0);
      repeat (3000) begin
         @(posedge clk); #1;
         in_valid = $urandom_range(0, 3) == 0;
         a = 8'($urandom);
         b = 8'($urandom);
         bin = 1'($urandom);
         out_ready = 1'($urandom);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("random_accepts", accepts > 50, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
